// File: rtl/my_keyboard.sv
// PS/2 keyboard front end: synchronizes the PS/2 lines, receives set-2 frames and
// tracks make/break/extended/shift state to present the held key's Hack code.
module my_keyboard #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_out,
    output logic        byte_valid,
    output logic        frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nxt;
    logic            clk_p0, clk_p1, clk_p2;
    logic            dat_p0, dat_p1;
    logic            fall;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [WD_W-1:0] wdog;
    logic            timeout;
    logic            accept, err_nxt;
    logic            ext_flag, brk_flag, shift_flag;
    logic [7:0]      key_q;
    logic [7:0]      dec_code;
    logic            dec_letter;
    logic [7:0]      upper_code;

    function automatic logic [7:0] base_code(input logic ext, input logic [7:0] b);
        logic [7:0] c;
        c = 8'd0;
        if (!ext) begin
            case (b)
                8'h1C: c = 8'd97;  8'h32: c = 8'd98;  8'h21: c = 8'd99;  8'h23: c = 8'd100;
                8'h24: c = 8'd101; 8'h2B: c = 8'd102; 8'h34: c = 8'd103; 8'h33: c = 8'd104;
                8'h43: c = 8'd105; 8'h3B: c = 8'd106; 8'h42: c = 8'd107; 8'h4B: c = 8'd108;
                8'h3A: c = 8'd109; 8'h31: c = 8'd110; 8'h44: c = 8'd111; 8'h4D: c = 8'd112;
                8'h15: c = 8'd113; 8'h2D: c = 8'd114; 8'h1B: c = 8'd115; 8'h2C: c = 8'd116;
                8'h3C: c = 8'd117; 8'h2A: c = 8'd118; 8'h1D: c = 8'd119; 8'h22: c = 8'd120;
                8'h35: c = 8'd121; 8'h1A: c = 8'd122;
                8'h45: c = 8'd48;  8'h16: c = 8'd49;  8'h1E: c = 8'd50;  8'h26: c = 8'd51;
                8'h25: c = 8'd52;  8'h2E: c = 8'd53;  8'h36: c = 8'd54;  8'h3D: c = 8'd55;
                8'h3E: c = 8'd56;  8'h46: c = 8'd57;
                8'h29: c = 8'd32;  8'h5A: c = 8'd128; 8'h66: c = 8'd129; 8'h76: c = 8'd140;
                default: c = 8'd0;
            endcase
        end else begin
            case (b)
                8'h6B: c = 8'd130; 8'h75: c = 8'd131; 8'h74: c = 8'd132; 8'h72: c = 8'd133;
                default: c = 8'd0;
            endcase
        end
        return c;
    endfunction

    // stage p0/p1: two-flop synchronizers; p2: previous clock level for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            clk_p2 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
            dat_p0 <= ps2_data;
            dat_p1 <= dat_p0;
        end
    end

    assign fall    = clk_p2 & ~clk_p1;
    // an edge always beats an expiring watchdog
    assign timeout = (state != IDLE) && !fall && (wdog == WD_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        err_nxt   = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_p1) state_nxt = DATA;
                    else         err_nxt   = 1'b1;
                end
                DATA:   if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY: state_nxt = STOP;
                STOP: begin
                    if (dat_p1 && (^{shreg, par_bit})) accept  = 1'b1;
                    else                                 err_nxt = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            par_bit    <= 1'b0;
            wdog       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_valid <= accept;
            frame_err  <= err_nxt;
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= 3'd0;
                    DATA: begin
                        shreg   <= {dat_p1, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par_bit <= dat_p1;
                    default: ;
                endcase
            end
            if (fall || state == IDLE)
                wdog <= '0;
            else if (wdog != WD_W'(TIMEOUT_CYCLES))
                wdog <= wdog + WD_W'(1);
        end
    end

    assign dec_code   = base_code(ext_flag, shreg);
    assign dec_letter = (dec_code >= 8'd97) && (dec_code <= 8'd122);
    assign upper_code = dec_code - 8'd32;

    // decoder: case is chosen at make time, a letter break matches either case
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            shift_flag <= 1'b0;
            key_q      <= 8'd0;
        end else if (accept) begin
            if (shreg == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (shreg == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                if (shreg == 8'h12 || shreg == 8'h59) begin
                    shift_flag <= !brk_flag;
                end else if (dec_code != 8'd0) begin
                    if (!brk_flag)
                        key_q <= (dec_letter && shift_flag) ? upper_code : dec_code;
                    else if (key_q == dec_code || (dec_letter && key_q == upper_code))
                        key_q <= 8'd0;
                end
            end
        end
    end

    assign key_out = {8'd0, key_q};

endmodule

// File: tb/tb_my_keyboard.sv
// Randomized and directed bench for my_keyboard against a table-driven keyboard model.
module tb_my_keyboard;

    localparam int TO   = 200;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_out;
    logic        byte_valid;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int bv_cnt = 0, fe_cnt = 0, both_cnt = 0;

    int m_key = 0;
    bit m_ext = 0, m_brk = 0, m_shift = 0;

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] spc_sc  [4]  = '{8'h29, 8'h5A, 8'h66, 8'h76};
    int         spc_hk  [4]  = '{32, 128, 129, 140};
    logic [7:0] ext_sc  [4]  = '{8'h6B, 8'h75, 8'h74, 8'h72};

    my_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_out(key_out), .byte_valid(byte_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid === 1'b1) bv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (byte_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_lookup(input logic [7:0] b, input bit e);
        if (e) begin
            for (int i = 0; i < 4; i++) if (ext_sc[i] == b) return 130 + i;
            return 0;
        end
        for (int i = 0; i < 26; i++) if (letters[i] == b) return 97 + i;
        for (int i = 0; i < 10; i++) if (digits[i] == b) return 48 + i;
        for (int i = 0; i < 4; i++) if (spc_sc[i] == b) return spc_hk[i];
        return 0;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int  code;
        bit  letter;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (b == 8'h12 || b == 8'h59) begin
                m_shift = !m_brk;
            end else begin
                code   = ref_lookup(b, m_ext);
                letter = (code >= 97 && code <= 122);
                if (code != 0) begin
                    if (!m_brk) m_key = (letter && m_shift) ? code - 32 : code;
                    else if (m_key == code || (letter && m_key == code - 32)) m_key = 0;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int n);
        logic [10:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = b[i];
        bits[9]  = (~^b) ^ bad_par;
        bits[10] = ~bad_stop;
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic xact(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int  bv0, fe0;
        bit  good;
        bv0  = bv_cnt;
        fe0  = fe_cnt;
        good = !bad_par && !bad_stop;
        send_bits(b, bad_par, bad_stop, 11);
        if (good) model_byte(b);
        chk({tag, ".key"}, key_out, m_key);
        chk({tag, ".bv"}, bv_cnt - bv0, good ? 1 : 0);
        chk({tag, ".fe"}, fe_cnt - fe0, good ? 0 : 1);
    endtask

    task automatic model_reset();
        m_key = 0; m_ext = 0; m_brk = 0; m_shift = 0;
    endtask

    initial begin
        int bv0, fe0, r;
        logic [7:0] b;
        bit bp, bs;

        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst.key", key_out, 0);
        chk("rst.bv", byte_valid, 0);
        chk("rst.fe", frame_err, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        xact("a_make", 8'h1C, 0, 0);
        chk("a_is_97", key_out, 97);
        xact("brk_pre", 8'hF0, 0, 0);
        xact("a_brk", 8'h1C, 0, 0);
        xact("a2", 8'h1C, 0, 0);
        xact("b_make", 8'h32, 0, 0);
        xact("brk_pre2", 8'hF0, 0, 0);
        xact("a_brk_ign", 8'h1C, 0, 0);
        chk("b_stays_98", key_out, 98);
        xact("brk_pre3", 8'hF0, 0, 0);
        xact("b_brk", 8'h32, 0, 0);

        xact("shift_dn", 8'h12, 0, 0);
        xact("A_make", 8'h1C, 0, 0);
        chk("A_is_65", key_out, 65);
        xact("brk_pre4", 8'hF0, 0, 0);
        xact("shift_up", 8'h12, 0, 0);
        xact("brk_pre5", 8'hF0, 0, 0);
        xact("A_brk", 8'h1C, 0, 0);

        xact("e0", 8'hE0, 0, 0);
        xact("up", 8'h75, 0, 0);
        chk("up_is_131", key_out, 131);
        xact("e0b", 8'hE0, 0, 0);
        xact("f0b", 8'hF0, 0, 0);
        xact("up_brk", 8'h75, 0, 0);
        xact("a3", 8'h1C, 0, 0);
        xact("kp8_unmapped", 8'h75, 0, 0);

        xact("bad_par", 8'h1C, 1, 0);
        xact("bad_stop", 8'h29, 0, 1);

        bv0 = bv_cnt; fe0 = fe_cnt;
        send_bits(8'h1C, 0, 0, 5);
        repeat (TO + 40) @(posedge clk);
        #1;
        chk("tmo.fe", fe_cnt - fe0, 1);
        chk("tmo.bv", bv_cnt - bv0, 0);
        xact("space", 8'h29, 0, 0);
        chk("space_is_32", key_out, 32);

        bv0 = bv_cnt; fe0 = fe_cnt;
        send_bits(8'h32, 0, 0, 4);
        @(posedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("midrst.key", key_out, 0);
        chk("midrst.pulses", (bv_cnt - bv0) + (fe_cnt - fe0), 0);
        xact("post_rst", 8'h1C, 0, 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      b = letters[$urandom_range(0, 25)];
            else if (r < 42) b = digits[$urandom_range(0, 9)];
            else if (r < 48) b = spc_sc[$urandom_range(0, 3)];
            else if (r < 62) b = 8'hF0;
            else if (r < 72) b = 8'hE0;
            else if (r < 82) b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
            else if (r < 92) b = ext_sc[$urandom_range(0, 3)];
            else             b = 8'($urandom_range(0, 255));
            bp = 0; bs = 0;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) bp = 1;
                else bs = 1;
            end
            xact("rnd", b, bp, bs);
        end

        chk("excl", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
